// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall-request, flush-redirect and perf/watchdog signals of the pipeline controller.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             excp_i;
  logic             eret_i;
  logic [31:0]      epc_i;
  logic             perf_clr;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic             stall_timeout;
  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excp_i, eret_i, epc_i, perf_clr,
    input  stall, flush, new_pc, stall_cycles, stall_timeout
  );
  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excp_i, eret_i, epc_i, perf_clr,
    output stall, flush, new_pc, stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall vector merge, exception/ERET flush sequencing, stall perf counter and watchdog.
module pipe_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          MAX_STALL    = 64,
  parameter int          CNT_W        = 32
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int WDW = $clog2(MAX_STALL + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t           state_q, state_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             to_q, to_d;
  logic [5:0]       stall_c;
  // stall is forced low while reset is asserted so every output reads 0 in reset
  assign stall_c = (!rst_n || state_q != RUN) ? 6'b000000 :
                   bus.stallreq_mem ? 6'b011111 :
                   bus.stallreq_ex  ? 6'b001111 :
                   bus.stallreq_id  ? 6'b000111 : 6'b000000;
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    tgt_d   = tgt_q;
    if (state_q == RUN) begin
      if (bus.excp_i || bus.eret_i) begin
        state_d = FLUSH;
        fcnt_d  = FCW'(FLUSH_CYCLES - 1);
        tgt_d   = bus.excp_i ? HANDLER_ADDR : bus.epc_i;
      end
    end else begin
      state_d = (fcnt_q == '0) ? RUN : FLUSH;
      fcnt_d  = (fcnt_q == '0) ? fcnt_q : fcnt_q - 1'b1;
    end
    cnt_d = bus.perf_clr ? '0 : stall_c[0] ? cnt_q + 1'b1 : cnt_q;
    wd_d  = (stall_c == '0) ? '0 : (wd_q == WDW'(MAX_STALL)) ? wd_q : wd_q + 1'b1;
    to_d  = to_q | (wd_d == WDW'(MAX_STALL));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end
  assign bus.stall         = stall_c;
  assign bus.flush         = (state_q == FLUSH);
  assign bus.new_pc        = tgt_q;
  assign bus.stall_cycles  = cnt_q;
  assign bus.stall_timeout = to_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed tests of stall priority, flush sequencing, perf counter and watchdog.
module tb_pipe_ctrl;
  localparam int CW = 4;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  pipe_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_ctrl #(.HANDLER_ADDR(32'h0000_0020), .FLUSH_CYCLES(FC), .MAX_STALL(64), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
    bus.excp_i = 0; bus.eret_i = 0; bus.epc_i = '0; bus.perf_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      bus.stallreq_id = 1'($urandom); bus.stallreq_ex = 1'($urandom); bus.stallreq_mem = 1'b1;
      bus.excp_i = 1'($urandom); bus.eret_i = 1'b1; bus.epc_i = $urandom; bus.perf_clr = 1'($urandom);
      #1;
      n_chk++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 000000", bus.stall); end
      n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
      n_chk++; if (bus.new_pc !== 32'h0) begin n_fail++; $display("FAIL reset_new_pc: got %h want 0", bus.new_pc); end
      n_chk++; if (bus.stall_cycles !== 4'h0) begin n_fail++; $display("FAIL reset_cycles: got %0d want 0", bus.stall_cycles); end
      n_chk++; if (bus.stall_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus.stall_timeout); end
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL idle_stall: got %b want 000000", bus.stall); end
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL idle_flush: got %b want 0", bus.flush); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    bus.stallreq_ex = 1; #1;
    n_chk++; if (bus.stall !== 6'b001111) begin n_fail++; $display("FAIL prio_ex: got %b want 001111", bus.stall); end
    bus.stallreq_id = 1; #1;
    n_chk++; if (bus.stall !== 6'b001111) begin n_fail++; $display("FAIL prio_ex_id: got %b want 001111", bus.stall); end
    bus.stallreq_mem = 1; #1;
    n_chk++; if (bus.stall !== 6'b011111) begin n_fail++; $display("FAIL prio_mem: got %b want 011111", bus.stall); end
    bus.stallreq_mem = 0; bus.stallreq_ex = 0; #1;
    n_chk++; if (bus.stall !== 6'b000111) begin n_fail++; $display("FAIL prio_id: got %b want 000111", bus.stall); end
    bus.stallreq_id = 0; #1;
    n_chk++; if (bus.stall !== 6'b000000) begin n_fail++; $display("FAIL prio_none: got %b want 000000", bus.stall); end
  endtask

  task automatic test_excp_flush();
    @(negedge clk);
    bus.stallreq_mem = 1; bus.excp_i = 1; #1;
    n_chk++; if (bus.stall !== 6'b011111) begin n_fail++; $display("FAIL excp_req_stall: got %b want 011111", bus.stall); end
    @(negedge clk);
    bus.excp_i = 0;
    n_chk++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL excp_flush1: got %b want 1", bus.flush); end
    n_chk++; if (bus.new_pc !== 32'h20) begin n_fail++; $display("FAIL excp_pc: got %h want 00000020", bus.new_pc); end
    n_chk++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL excp_flush_stall: got %b want 000000", bus.stall); end
    @(negedge clk);
    n_chk++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL excp_flush2: got %b want 1", bus.flush); end
    @(negedge clk);
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL excp_flush_end: got %b want 0", bus.flush); end
    n_chk++; if (bus.stall !== 6'b011111) begin n_fail++; $display("FAIL excp_resume_stall: got %b want 011111", bus.stall); end
    bus.stallreq_mem = 0;
  endtask

  task automatic test_eret();
    @(negedge clk);
    bus.eret_i = 1; bus.epc_i = 32'h8000_1234;
    @(negedge clk);
    bus.eret_i = 0; bus.epc_i = '0;
    n_chk++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h8000_1234) begin n_fail++; $display("FAIL eret_c1: got flush=%b pc=%h want 1 80001234", bus.flush, bus.new_pc); end
    @(negedge clk);
    n_chk++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h8000_1234) begin n_fail++; $display("FAIL eret_c2: got flush=%b pc=%h want 1 80001234", bus.flush, bus.new_pc); end
    @(negedge clk);
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL eret_end: got %b want 0", bus.flush); end
    n_chk++; if (bus.new_pc !== 32'h8000_1234) begin n_fail++; $display("FAIL eret_keep_pc: got %h want 80001234", bus.new_pc); end
  endtask

  task automatic test_both_and_ignore();
    @(negedge clk);
    bus.excp_i = 1; bus.eret_i = 1; bus.epc_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.excp_i = 0; bus.eret_i = 1; bus.epc_i = 32'h1111_0000;
    n_chk++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h20) begin n_fail++; $display("FAIL both_pc: got flush=%b pc=%h want 1 00000020", bus.flush, bus.new_pc); end
    @(negedge clk);
    bus.eret_i = 0; bus.excp_i = 1;
    n_chk++; if (bus.flush !== 1'b1 || bus.new_pc !== 32'h20) begin n_fail++; $display("FAIL ignore_pc: got flush=%b pc=%h want 1 00000020", bus.flush, bus.new_pc); end
    @(negedge clk);
    bus.excp_i = 0;
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL ignore_end: got %b want 0", bus.flush); end
    @(negedge clk);
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL ignore_no_second: got %b want 0", bus.flush); end
    n_chk++; if (bus.new_pc !== 32'h20) begin n_fail++; $display("FAIL ignore_keep_pc: got %h want 00000020", bus.new_pc); end
  endtask

  task automatic test_perf();
    @(negedge clk);
    bus.perf_clr = 1;
    @(negedge clk);
    bus.perf_clr = 0;
    n_chk++; if (bus.stall_cycles !== 4'd0) begin n_fail++; $display("FAIL perf_clr_idle: got %0d want 0", bus.stall_cycles); end
    bus.stallreq_ex = 1;
    repeat (15) @(negedge clk);
    n_chk++; if (bus.stall_cycles !== 4'd15) begin n_fail++; $display("FAIL perf_15: got %0d want 15", bus.stall_cycles); end
    @(negedge clk);
    n_chk++; if (bus.stall_cycles !== 4'd0) begin n_fail++; $display("FAIL perf_wrap: got %0d want 0", bus.stall_cycles); end
    repeat (3) @(negedge clk);
    n_chk++; if (bus.stall_cycles !== 4'd3) begin n_fail++; $display("FAIL perf_3: got %0d want 3", bus.stall_cycles); end
    bus.perf_clr = 1;
    @(negedge clk);
    bus.perf_clr = 0; bus.stallreq_ex = 0;
    n_chk++; if (bus.stall_cycles !== 4'd0) begin n_fail++; $display("FAIL perf_clr_stalled: got %0d want 0", bus.stall_cycles); end
    @(negedge clk);
    n_chk++; if (bus.stall_cycles !== 4'd0) begin n_fail++; $display("FAIL perf_hold: got %0d want 0", bus.stall_cycles); end
  endtask

  task automatic test_watchdog();
    @(negedge clk);
    bus.stallreq_id = 1;
    repeat (63) @(negedge clk);
    n_chk++; if (bus.stall_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_63: got %b want 0", bus.stall_timeout); end
    @(negedge clk);
    n_chk++; if (bus.stall_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_64: got %b want 1", bus.stall_timeout); end
    n_chk++; if (bus.stall !== 6'b000111) begin n_fail++; $display("FAIL wd_stall_kept: got %b want 000111", bus.stall); end
    bus.stallreq_id = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.stall_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %b want 1", bus.stall_timeout); end
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk);
    bus.excp_i = 1;
    @(negedge clk);
    bus.excp_i = 0;
    n_chk++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL mid_flush_on: got %b want 1", bus.flush); end
    #2 rst_n = 0;
    #1;
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL mid_flush_drop: got %b want 0", bus.flush); end
    n_chk++; if (bus.stall_timeout !== 1'b0) begin n_fail++; $display("FAIL mid_timeout_clr: got %b want 0", bus.stall_timeout); end
    n_chk++; if (bus.new_pc !== 32'h0) begin n_fail++; $display("FAIL mid_pc_clr: got %h want 0", bus.new_pc); end
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL mid_after: got %b want 0", bus.flush); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_priority();
    test_excp_flush();
    test_eret();
    test_both_and_ignore();
    test_perf();
    test_watchdog();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
